data_ram: RTL and testbench
===========================

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter ADDR_BITS, default 12, gives the byte-address width (1 << (ADDR_BITS-2) words).
REQ-002 Parameter DATA_BITS, default 32, gives the word width; only 32 is supported.
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req  in  1  access request, sampled when ready=1.
REQ-006 we  in  1  1=store, 0=load.
REQ-007 size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
REQ-009 addr  in  ADDR_BITS  byte address.
REQ-010 wdata  in  DATA_BITS  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 ready  out  1  block can accept a request this cycle.
REQ-012 rvalid  out  1  one-cycle response pulse.
REQ-013 rdata  out  DATA_BITS  load result; 0 for stores and errors.
REQ-014 err  out  1  qualifies rvalid: misaligned access or reserved size.

Function
REQ-015 The FSM SHALL have two states: IDLE (ready=1) and RESP (ready=0, rvalid=1).
REQ-016 Acceptance SHALL occur on the rising edge where req=1 and state=IDLE; the FSM then moves to RESP. Otherwise it stays in IDLE.
REQ-017 RESP SHALL last exactly one cycle, then return to IDLE. Latency is request edge to rvalid = 1 cycle. Throughput is 1 access per 2 cycles.
REQ-018 There SHALL be no response back-pressure; the response is a single-cycle pulse.
REQ-019 Byte lanes SHALL be little-endian: lane k holds bits [8k+7:8k] of the word at addr[ADDR_BITS-1:2].
REQ-020 Stores SHALL write memory on the accepting edge:
- SB writes wdata[7:0] to lane addr[1:0].
- SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
- SW writes all lanes.
- Unselected lanes SHALL be unchanged.
REQ-021 Loads SHALL register the addressed word on the accepting edge. rdata in RESP SHALL be the selected byte or half, shifted to bit 0 and extended per sign_ext; LW returns the word.
REQ-022 Misalignment:
- half with addr[0]=1, or word with addr[1:0]!=0, SHALL set err=1 in RESP.
- Any access with size=11 SHALL set err=1 in RESP.
- An erroring access SHALL perform no write and return rdata=0.
REQ-023 rdata and err SHALL be 0 whenever rvalid=0.
REQ-024 Memory contents SHALL be zero at simulation start and SHALL NOT be cleared by reset.
REQ-025 Address wrap-around SHALL NOT occur: every ADDR_BITS-bit address maps uniquely.
REQ-026 A load immediately following a store to the same word SHALL return the updated data.

Reset
REQ-027 While rst_n=0, the block SHALL hold state=IDLE, ready=1, rvalid=0, rdata=0, err=0.
REQ-028 Reset asserted during RESP SHALL drop rvalid asynchronously. A store already written on the accepting edge SHALL remain written.
REQ-029 Reset asserted before the accepting edge SHALL cause no write.
REQ-030 The first acceptance SHALL occur on the first rising edge after rst_n deasserts with req=1.

Structure
REQ-031 A shared package SHALL hold:
- size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD);
- the FSM state type;
- the DATA_BITS constant.
REQ-032 One combinational sub-module, data_ram_align, SHALL generate the 4-bit byte-enable, the aligned write data, the err flag, and the load extraction/extension.
REQ-033 The storage array SHALL use a single synchronous write port and a registered read, so it infers block RAM.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset then SW addr=0x010 wdata=0xDEADBEEF, then LW 0x010 -> RESP rdata=0xDEADBEEF, err=0, ready low exactly 1 cycle each access.
- After that, SB 0x011 wdata=0x000000AA, then LW 0x010 -> 0xDEADAAEF; LB 0x011 sign_ext=1 -> 0xFFFFFFAA; LBU -> 0x000000AA.
- SH 0x012 wdata=0x00008001, then LH 0x012 sign_ext=1 -> 0xFFFF8001; LHU -> 0x00008001; LW 0x010 -> 0x8001AAEF.
- LW 0x013, SH 0x011, and size=11 at 0x020 -> err=1, rdata=0; subsequent LW 0x010 still 0x8001AAEF (no write).
- req held high for 6 cycles -> exactly 3 accepted, rvalid pattern 0,1,0,1,0,1.
- rst_n low mid-RESP of LW -> rvalid, rdata, err 0 immediately; after release, memory retains prior stores.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data_ram block: access size encodings,
// FSM state type and the supported word width.
package data_ram_pkg;

    localparam int DATA_BITS = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

endpackage

// File: rtl/data_ram_align.sv
// Combinational lane logic: store byte-enables, replicated write data and the
// alignment error flag, plus load extraction and sign/zero extension.
module data_ram_align
    import data_ram_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic        err,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_sign,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Data is replicated across lanes so the byte-enables alone pick the target.
    always_comb begin
        be       = 4'b0000;
        wdata_al = 32'h0;
        err      = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wdata_al = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
                err      = addr_lo[0];
            end
            SIZE_WORD: begin
                be       = 4'b1111;
                wdata_al = wdata;
                err      = (addr_lo != 2'b00);
            end
            default: err = 1'b1;
        endcase
        if (err)
            be = 4'b0000;
    end

    always_comb begin
        byte_v  = ld_word[8*ld_off +: 8];
        half_v  = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = 32'h0;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_sign & byte_v[7]}}, byte_v};
            SIZE_HALF: ld_data = {{16{ld_sign & half_v[15]}}, half_v};
            SIZE_WORD: ld_data = ld_word;
            default:   ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// Byte-addressable data RAM with a two-state IDLE/RESP handshake: one access
// per two cycles, single-cycle response pulse, misaligned/reserved accesses flagged.
module data_ram #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = data_ram_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [1:0]           size,
    input  logic                 sign_ext,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 ready,
    output logic                 rvalid,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 err,
    output logic                 state_dbg
);
    import data_ram_pkg::*;

    // Handshake: a request is taken on a rising edge where req=1 and ready=1;
    // the response is a one-cycle rvalid pulse on the next cycle with no back-pressure.
    localparam int WORDS = 1 << (ADDR_BITS - 2);

    state_e state, state_next;

    logic [DATA_BITS-1:0] mem [WORDS];
    logic [DATA_BITS-1:0] rd_word;
    logic [ADDR_BITS-3:0] word_addr;
    logic                 accept;
    logic                 wr_en;
    logic [3:0]           be;
    logic [DATA_BITS-1:0] wdata_al;
    logic                 acc_err;
    logic                 we_q, sign_q, err_q;
    logic [1:0]           size_q, off_q;
    logic [DATA_BITS-1:0] ld_data;

    assign word_addr = addr[ADDR_BITS-1:2];
    assign accept    = req && (state == ST_IDLE);
    // rst_n gates the write so a store presented while in reset is dropped.
    assign wr_en     = accept && we && !acc_err && rst_n;

    data_ram_align u_align (
        .size     (size),
        .addr_lo  (addr[1:0]),
        .wdata    (wdata),
        .be       (be),
        .wdata_al (wdata_al),
        .err      (acc_err),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_sign  (sign_q),
        .ld_word  (rd_word),
        .ld_data  (ld_data)
    );

    // Storage: single write port with lane enables and a registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k])
                    mem[word_addr][8*k +: 8] <= wdata_al[8*k +: 8];
            end
        end
        if (accept)
            rd_word <= mem[word_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            sign_q <= 1'b0;
            err_q  <= 1'b0;
            size_q <= SIZE_BYTE;
            off_q  <= 2'b00;
        end else if (accept) begin
            we_q   <= we;
            sign_q <= sign_ext;
            err_q  <= acc_err;
            size_q <= size;
            off_q  <= addr[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = req ? ST_RESP : ST_IDLE;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == ST_IDLE);
        rvalid = (state == ST_RESP);
        err    = rvalid && err_q;
        rdata  = (rvalid && !err_q && !we_q) ? ld_data : '0;
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: stores/loads of every size, alignment errors,
// back-to-back requests and reset during a response.
module tb_data_ram;

    localparam int AB = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          sign_ext = 1'b0;
    logic [AB-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic          ready, rvalid, err, state_dbg;
    logic [31:0]   rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    data_ram #(.ADDR_BITS(AB), .DATA_BITS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Starts and ends on a falling edge; checks ready before, the response pulse, and idle after.
    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [AB-1:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        check({tag, ".ready_pre"}, {31'b0, ready}, 32'd1);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check({tag, ".rvalid"}, {31'b0, rvalid}, 32'd1);
        check({tag, ".ready_resp"}, {31'b0, ready}, 32'd0);
        check({tag, ".rdata"}, rdata, exp_rd);
        check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
        @(negedge clk);
        check({tag, ".ready_post"}, {31'b0, ready}, 32'd1);
        check({tag, ".rvalid_post"}, {31'b0, rvalid}, 32'd0);
        check({tag, ".rdata_post"}, rdata, 32'd0);
    endtask

    initial begin
        int accepted;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst.ready", {31'b0, ready}, 32'd1);
        check("rst.rvalid", {31'b0, rvalid}, 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.err", {31'b0, err}, 32'd0);
        check("rst.state", {31'b0, state_dbg}, 32'd0);
        rst_n = 1'b1;

        access("sw010", 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0);
        access("lw010a", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0);
        access("sb011", 1'b1, 2'b00, 1'b0, 12'h011, 32'h000000AA, 32'h0, 1'b0);
        access("lw010b", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hDEADAAEF, 1'b0);
        access("lb011", 1'b0, 2'b00, 1'b1, 12'h011, 32'h0, 32'hFFFFFFAA, 1'b0);
        access("lbu011", 1'b0, 2'b00, 1'b0, 12'h011, 32'h0, 32'h000000AA, 1'b0);
        access("sh012", 1'b1, 2'b01, 1'b0, 12'h012, 32'h00008001, 32'h0, 1'b0);
        access("lh012", 1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 32'hFFFF8001, 1'b0);
        access("lhu012", 1'b0, 2'b01, 1'b0, 12'h012, 32'h0, 32'h00008001, 1'b0);
        access("lw010c", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h8001AAEF, 1'b0);
        access("lbu010", 1'b0, 2'b00, 1'b0, 12'h010, 32'h0, 32'h000000EF, 1'b0);
        access("lh010", 1'b0, 2'b01, 1'b1, 12'h010, 32'h0, 32'hFFFFAAEF, 1'b0);

        // Alignment and reserved-size errors: no write, rdata forced to zero
        access("lw013", 1'b0, 2'b10, 1'b0, 12'h013, 32'h0, 32'h0, 1'b1);
        access("sh011", 1'b1, 2'b01, 1'b0, 12'h011, 32'h00001234, 32'h0, 1'b1);
        access("sw012", 1'b1, 2'b10, 1'b0, 12'h012, 32'h55555555, 32'h0, 1'b1);
        access("rsv020", 1'b0, 2'b11, 1'b0, 12'h020, 32'h0, 32'h0, 1'b1);
        access("rsvst010", 1'b1, 2'b11, 1'b0, 12'h010, 32'h77777777, 32'h0, 1'b1);
        access("lw010d", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h8001AAEF, 1'b0);

        // Top word must not alias word 0
        access("sw_top", 1'b1, 2'b10, 1'b0, 12'hFFC, 32'hCAFEF00D, 32'h0, 1'b0);
        access("lw_top", 1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0, 32'hCAFEF00D, 1'b0);
        access("sw000", 1'b1, 2'b10, 1'b0, 12'h000, 32'h01020304, 32'h0, 1'b0);
        access("lw_top2", 1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0, 32'hCAFEF00D, 1'b0);

        // req held for six edges: every other one is accepted
        exp_q = {32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
        accepted = 0;
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 12'h010;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b2b.rvalid%0d", i), {31'b0, rvalid}, exp_q.pop_front());
            if (ready) accepted++;
            @(posedge clk);
            @(negedge clk);
        end
        req = 1'b0;
        check("b2b.accepted", accepted, 32'd3);
        check("b2b.idle_after", {31'b0, rvalid}, 32'd0);

        // Reset asserted mid-response drops outputs immediately
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 12'h010;
        @(posedge clk);
        #2;
        req = 1'b0;
        check("mid.rvalid_before", {31'b0, rvalid}, 32'd1);
        check("mid.rdata_before", rdata, 32'h8001AAEF);
        rst_n = 1'b0;
        #1;
        check("mid.rvalid", {31'b0, rvalid}, 32'd0);
        check("mid.rdata", rdata, 32'd0);
        check("mid.err", {31'b0, err}, 32'd0);
        check("mid.ready", {31'b0, ready}, 32'd1);
        // A store presented while reset is held must not write
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 12'h010; wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("inrst.rvalid", {31'b0, rvalid}, 32'd0);
        rst_n = 1'b1;
        access("lw010e", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h8001AAEF, 1'b0);
        access("lw000", 1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 32'h01020304, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends with a summary line
    initial begin
        #100000;
        n_checks++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
